// File: rtl/rast_params.sv
`default_nettype none
// rast_params: shared rasterizer constants and triangle/colour storage types.
package rast_params;

  localparam int SIGFIG     = 24;
  localparam int RADIX      = 10;
  localparam int VERTS      = 3;
  localparam int AXIS       = 3;
  localparam int COLORS     = 3;
  localparam int FIFO_DEPTH = 4;

  typedef logic signed [SIGFIG-1:0] coord_t;
  typedef coord_t [AXIS-1:0]         vertex_t;
  typedef vertex_t [VERTS-1:0]       tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

  localparam int TRI_BITS   = $bits(tri_t);
  localparam int COLOR_BITS = $bits(color_t);

endpackage
`default_nettype wire

// File: rtl/rast_sync_fifo.sv
`default_nettype none
// rast_sync_fifo: generic circular queue; occupancy counter decides full/empty.
module rast_sync_fifo
  import rast_params::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;

  // Output forced to zero while empty so nothing stale is ever presented.
  assign head_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/tri_fifo.sv
`default_nettype none
// tri_fifo: triangle input buffer ahead of bbox, with backpressure both ways.
// Optional back-face culling at push time: TRI_FIFO_BACKFACE_CULL_EN.
module tri_fifo
  import rast_params::*;
#(
  parameter int DEPTH  = rast_params::FIFO_DEPTH,
  parameter int SIGFIG = rast_params::SIGFIG,
  parameter int VERTS  = rast_params::VERTS,
  parameter int AXIS   = rast_params::AXIS,
  parameter int COLORS = rast_params::COLORS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_in,
  input  logic [COLORS*SIGFIG-1:0]        color_in,
  input  logic                            valid_in,
  output logic                            halt_out_L,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_out,
  output logic [COLORS*SIGFIG-1:0]        color_out,
  output logic                            valid_out,
  input  logic                            halt_in_L,
  output logic [$clog2(DEPTH+1)-1:0]      count_out
`ifdef TRI_FIFO_BACKFACE_CULL_EN
  ,
  output logic [15:0]                     cull_cnt_out
`endif
);

  localparam int TW = VERTS * AXIS * SIGFIG;
  localparam int CW = COLORS * SIGFIG;

  tri_t   tri_s;
  color_t color_s;
  logic   full;
  logic   accept;
  logic   write_en;
  logic   culled;
  logic [TW+CW-1:0] head;

  assign tri_s   = tri_t'(tri_in);
  assign color_s = color_t'(color_in);

  // halt_out_L depends only on registered occupancy, never on halt_in_L.
  assign halt_out_L = !full;
  assign accept     = valid_in && halt_out_L;
  assign write_en   = accept && !culled;

`ifdef TRI_FIFO_BACKFACE_CULL_EN
  localparam int PW = 2 * SIGFIG + 3;

  logic signed [SIGFIG:0] dx1, dy1, dx2, dy2;
  logic signed [PW-1:0]   p1, p2, area;

  always_comb begin
    dx1  = {tri_s[1][0][SIGFIG-1], tri_s[1][0]} - {tri_s[0][0][SIGFIG-1], tri_s[0][0]};
    dy1  = {tri_s[1][1][SIGFIG-1], tri_s[1][1]} - {tri_s[0][1][SIGFIG-1], tri_s[0][1]};
    dx2  = {tri_s[2][0][SIGFIG-1], tri_s[2][0]} - {tri_s[0][0][SIGFIG-1], tri_s[0][0]};
    dy2  = {tri_s[2][1][SIGFIG-1], tri_s[2][1]} - {tri_s[0][1][SIGFIG-1], tri_s[0][1]};
    p1   = PW'(dx1) * PW'(dy2);
    p2   = PW'(dx2) * PW'(dy1);
    area = p1 - p2;
    // Clockwise or degenerate triangles cover no pixels downstream.
    culled = area[PW-1] || (area == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cull_cnt_out <= '0;
    end else if (accept && culled && (cull_cnt_out != 16'hFFFF)) begin
      cull_cnt_out <= cull_cnt_out + 16'd1;
    end
  end
`else
  assign culled = 1'b0;
`endif

  rast_sync_fifo #(
    .WIDTH (TW + CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (write_en),
    .push_data ({tri_s, color_s}),
    .pop       (halt_in_L),
    .head_data (head),
    .valid     (valid_out),
    .full      (full),
    .count     (count_out)
  );

  assign tri_out   = head[TW+CW-1:CW];
  assign color_out = head[CW-1:0];

endmodule
`default_nettype wire

// File: tb/tb_tri_fifo.sv
`default_nettype none
// tb_tri_fifo: directed + random stimulus against a queue-based reference model.
module tb_tri_fifo;

  localparam int DEPTH = 4;
  localparam int SF    = 24;
  localparam int TW    = 9 * SF;
  localparam int CWID  = 3 * SF;

  logic            clk = 1'b0;
  logic            rst;
  logic [TW-1:0]   tri_in;
  logic [CWID-1:0] color_in;
  logic            valid_in;
  logic            halt_out_L;
  logic [TW-1:0]   tri_out;
  logic [CWID-1:0] color_out;
  logic            valid_out;
  logic            halt_in_L;
  logic [2:0]      count_out;
`ifdef TRI_FIFO_BACKFACE_CULL_EN
  logic [15:0]     cull_cnt_out;
`endif

  tri_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .tri_in     (tri_in),
    .color_in   (color_in),
    .valid_in   (valid_in),
    .halt_out_L (halt_out_L),
    .tri_out    (tri_out),
    .color_out  (color_out),
    .valid_out  (valid_out),
    .halt_in_L  (halt_in_L),
    .count_out  (count_out)
`ifdef TRI_FIFO_BACKFACE_CULL_EN
    ,
    .cull_cnt_out (cull_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [TW+CWID-1:0] q[$];
  int unsigned cull_exp = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic longint coord(input logic [TW-1:0] t, input int v, input int a);
    logic signed [SF-1:0] c;
    c = t[(v*3+a)*SF +: SF];
    return longint'(c);
  endfunction

  function automatic bit is_culled(input logic [TW-1:0] t);
    bit r;
    r = 1'b0;
`ifdef TRI_FIFO_BACKFACE_CULL_EN
    begin
      longint area;
      area = (coord(t,1,0) - coord(t,0,0)) * (coord(t,2,1) - coord(t,0,1))
           - (coord(t,2,0) - coord(t,0,0)) * (coord(t,1,1) - coord(t,0,1));
      r = (area <= 0);
    end
`endif
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_tri();
    logic [TW-1:0] t;
    for (int i = 0; i < 9; i++) t[i*SF +: SF] = SF'($urandom);
    return t;
  endfunction

  function automatic logic [TW-1:0] mk_tri(input int x0, input int y0, input int x1,
                                           input int y1, input int x2, input int y2);
    logic [TW-1:0] t;
    t = rand_tri();
    t[0*SF +: SF] = SF'(x0);  t[1*SF +: SF] = SF'(y0);
    t[3*SF +: SF] = SF'(x1);  t[4*SF +: SF] = SF'(y1);
    t[6*SF +: SF] = SF'(x2);  t[7*SF +: SF] = SF'(y2);
    return t;
  endfunction

  function automatic logic [CWID-1:0] rand_color();
    logic [95:0] tmp;
    tmp = {$urandom, $urandom, $urandom};
    return tmp[CWID-1:0];
  endfunction

  // One clock: apply inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit v, input logic [TW-1:0] t, input logic [CWID-1:0] c,
                       input bit h, output bit acc);
    bit pop;
    logic [TW+CWID-1:0] head;
    valid_in = v; tri_in = t; color_in = c; halt_in_L = h;
    @(negedge clk);
    head = (q.size() != 0) ? q[0] : '0;
    check("valid_out", valid_out, q.size() != 0);
    check("count_out", count_out, q.size());
    check("halt_out_L", halt_out_L, q.size() != DEPTH);
    check("tri_out", tri_out, head[TW+CWID-1:CWID]);
    check("color_out", color_out, head[CWID-1:0]);
`ifdef TRI_FIFO_BACKFACE_CULL_EN
    check("cull_cnt_out", cull_cnt_out, cull_exp);
`endif
    acc = v && (q.size() != DEPTH);
    pop = (q.size() != 0) && h;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (is_culled(t)) begin
        if (cull_exp != 32'hFFFF) cull_exp++;
      end else begin
        q.push_back({t, c});
      end
    end
    #1;
  endtask

  task automatic push(input logic [TW-1:0] t, input bit h);
    bit acc;
    cycle(1'b1, t, rand_color(), h, acc);
  endtask

  task automatic idle(input bit h, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, rand_tri(), rand_color(), h, acc);
  endtask

  initial begin
    bit acc;
    logic [TW-1:0] t6;
    logic [CWID-1:0] c6;
    rst = 1'b1; valid_in = 1'b0; halt_in_L = 1'b0; tri_in = '0; color_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b0, 2);

    // Two entries queued, then asynchronous reset with no clock edge.
    push(mk_tri(0,0,4,0,0,4), 1'b0);
    push(mk_tri(0,0,8,0,0,8), 1'b0);
    idle(1'b0, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_count_out", count_out, 3'd0);
    check("rst_halt_out_L", halt_out_L, 1'b1);
    check("rst_tri_out", tri_out, '0);
    q.delete();
    cull_exp = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // First push after reset, then fill to DEPTH with bbox stalled.
    for (int i = 0; i < 4; i++) push(mk_tri(0,0,4+i,0,0,4), 1'b0);
    for (int i = 0; i < 3; i++) push(mk_tri(0,0,9,0,0,9), 1'b0);  // refused while full
    idle(1'b1, 5);                                                 // drain in order

    // Simultaneous push/pop at count=2, long enough to wrap pointers.
    push(mk_tri(0,0,2,0,0,2), 1'b0);
    push(mk_tri(0,0,3,0,0,3), 1'b0);
    for (int i = 0; i < 10; i++) push(mk_tri(0,0,10+i,0,0,5), 1'b1);

    // Full plus pop: refused on the popping cycle, accepted next cycle.
    push(mk_tri(0,0,5,0,0,6), 1'b0);
    push(mk_tri(0,0,6,0,0,6), 1'b0);
    t6 = mk_tri(0,0,7,0,0,7);
    c6 = rand_color();
    cycle(1'b1, t6, c6, 1'b1, acc);
    check("full_pop_refused", acc, 1'b0);
    cycle(1'b1, t6, c6, 1'b0, acc);
    check("retry_accepted", acc, 1'b1);
    idle(1'b1, 5);

    // Orientation cases (culled only when the feature is built in).
    push(mk_tri(0,0,4,0,0,4), 1'b0);
    push(mk_tri(0,0,0,4,4,0), 1'b0);
    push(mk_tri(0,0,1,1,2,2), 1'b0);
    idle(1'b1, 4);

    // Random traffic; source holds its triangle until accepted.
    begin
      bit v = 1'b0;
      logic [TW-1:0] pt = rand_tri();
      logic [CWID-1:0] pc = rand_color();
      for (int i = 0; i < 400; i++) begin
        if (!v) begin
          v  = ($urandom_range(3) != 0);
          pt = rand_tri();
          pc = rand_color();
        end
        cycle(v, pt, pc, ($urandom_range(2) != 0), acc);
        if (acc) v = 1'b0;
      end
    end
    idle(1'b1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tri_fifo.md
Name: tri_fifo

Overview:
- Triangle input buffer directly upstream of the bounding-box stage.
- Accepts micropolygons (vertices plus color) from the vertex source.
- Holds them in a small circular queue and presents them to bbox under its halt backpressure.
- Decouples source bursts from bbox/iter stalls; bbox input timing stays unchanged.

Parameters:
- DEPTH, 4, number of triangle entries; power of two, minimum 2.
- SIGFIG, rast_params::SIGFIG (24), bits per coordinate/color component.
- VERTS, rast_params::VERTS (3), vertices per triangle.
- AXIS, rast_params::AXIS (3), axes per vertex.
- COLORS, rast_params::COLORS (3), color channels.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- tri_in  in  VERTS*AXIS*SIGFIG  incoming vertices, signed fixed point with RADIX fraction bits.
- color_in  in  COLORS*SIGFIG  incoming color.
- valid_in  in  1  triangle present on tri_in/color_in.
- halt_out_L  out  1  active-low stall to source; 0 = full, source must hold.
- tri_out  out  VERTS*AXIS*SIGFIG  head triangle to bbox.
- color_out  out  COLORS*SIGFIG  head color to bbox.
- valid_out  out  1  head entry valid.
- halt_in_L  in  1  active-low stall from bbox; 1 = bbox takes the head this cycle.
- count_out  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous-clean release) forces:
  - rd/wr pointers and count to 0;
  - valid_out=0, halt_out_L=1, count_out=0;
  - tri_out/color_out to 0 (storage array not reset).
- Push: valid_in && halt_out_L at a rising edge. Entry is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: valid_out && halt_in_L at a rising edge. rd_ptr increments modulo DEPTH.
- halt_out_L = !(count==DEPTH), from registered state only. There is no combinational path from halt_in_L to halt_out_L.
- When full, a push is refused even if a pop occurs in the same cycle. The source retries next cycle.
- valid_out = (count!=0). tri_out/color_out come from mem[rd_ptr].
- Latency: a triangle pushed at edge N is visible with valid_out=1 after edge N (cycle N+1) when the queue was empty. There is no bypass path.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Pop when empty: impossible, since valid_out=0. A halt_in_L toggle while empty has no effect.
- A push while valid_in=1 and halt_out_L=0 is ignored. The source must hold data stable until accepted.
- Head stability: while valid_out && !halt_in_L, tri_out/color_out/valid_out are held constant.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not pointer equality.
- Reset mid-operation discards all entries; no partial triangle is emitted afterwards.
- count_out tracks occupancy exactly: +1 on push only, -1 on pop only.

Optional Feature:
- Macro TRI_FIFO_BACKFACE_CULL_EN.
- With the macro defined:
  - At push, compute the signed area A = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0).
  - Differences are SIGFIG+1 bits; products and A are 2*SIGFIG+3 bits signed.
  - If A<=0 (clockwise or degenerate), the handshake completes (accepted, halt_out_L unaffected) but nothing is written; count unchanged.
  - Extra output cull_cnt_out (16 bits) increments per culled triangle and saturates at 0xFFFF. Reset value is 0.
- Without the macro: all accepted triangles are enqueued, and cull_cnt_out does not exist.

Decomposition:
- Add to rast_params:
  - vertex_t (AXIS x signed SIGFIG);
  - tri_t (VERTS x vertex_t);
  - color_t (COLORS x SIGFIG);
  - FIFO_DEPTH=4.
- tri_fifo uses tri_t/color_t internally. Ports stay flat vectors for bbox compatibility.
- Natural sub-module: rast_sync_fifo (generic width/depth storage, pointers, count). tri_fifo wraps it with triangle packing and the optional cull logic.

Test Plan:
- Reset then idle:
  - rst=1 mid-stream with 2 entries queued → valid_out=0, count_out=0, halt_out_L=1 immediately, no clock needed.
  - After release, the first push of triangle T0 → valid_out=1 the next cycle, tri_out=T0.
- Fill with halt_in_L=0 (DEPTH=4):
  - Push T0..T3 → count_out=4, halt_out_L=0.
  - Push T4 held 3 cycles → not accepted, count stays 4.
- Drain order: from full, set halt_in_L=1 → T0,T1,T2,T3 on consecutive cycles, then valid_out=0 and count_out=0.
- Simultaneous push/pop:
  - count=2, push T5 while popping → count stays 2, next head correct.
  - Repeat 10 cycles to force pointer wrap → output order matches input order.
- Full plus pop: count=4, push T6 with halt_in_L=1 → pop occurs, T6 refused (count=3). T6 is accepted on the next cycle, count=4.
- With TRI_FIFO_BACKFACE_CULL_EN:
  - Push CCW (0,0),(4,0),(0,4) → enqueued.
  - Push CW (0,0),(0,4),(4,0) → accepted but dropped, cull_cnt_out=1.
  - Push collinear (0,0),(1,1),(2,2) → dropped, cull_cnt_out=2.
